// File: rtl/alu_pkg.sv
// Shared encodings and the issue payload for the alu issue stage.
package alu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned CMP_W = 2;
    localparam int unsigned REG_W = 5;

    // alu_op commands: bit5:4 class, low bits select within the class
    localparam logic [OP_W-1:0] ALU_ZERO  = 6'b000000;
    localparam logic [OP_W-1:0] ALU_ADD   = 6'b010000;
    localparam logic [OP_W-1:0] ALU_SUB   = 6'b010001;
    localparam logic [OP_W-1:0] ALU_AND   = 6'b101000;
    localparam logic [OP_W-1:0] ALU_OR    = 6'b101110;
    localparam logic [OP_W-1:0] ALU_XOR   = 6'b100110;
    localparam logic [OP_W-1:0] ALU_PASSB = 6'b101010;
    localparam logic [OP_W-1:0] ALU_SLL   = 6'b110000;
    localparam logic [OP_W-1:0] ALU_SRL   = 6'b110001;
    localparam logic [OP_W-1:0] ALU_SRA   = 6'b110011;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // OP / OP-IMM funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // compare request carried alongside a SUB
    localparam logic [CMP_W-1:0] CMP_NONE = 2'b00;
    localparam logic [CMP_W-1:0] CMP_SLT  = 2'b01;
    localparam logic [CMP_W-1:0] CMP_SLTU = 2'b10;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [CMP_W-1:0] cmp;
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decode into an alu command plus operands.
module alu_issue_dec
    import alu_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output issue_t      dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt_i;
    logic        is_imm;
    logic        f7_base;
    logic        f7_alt;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign funct7  = inst_i[31:25];
    assign rd_f    = inst_i[11:7];
    assign imm_i   = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_u   = {inst_i[31:12], 12'b0};
    assign shamt_i = {27'b0, inst_i[24:20]};
    assign is_imm  = (opcode == OPC_OP_IMM);
    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);

    logic   legal;
    logic   writes;
    issue_t d;

    // Classify opcode/funct, pick command and operands; collapse illegal to ZERO.
    always_comb begin
        d      = '0;
        legal  = 1'b0;
        writes = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                legal  = 1'b1;
                writes = 1'b1;
                d.a    = rs1_i;
                d.b    = is_imm ? imm_i : rs2_i;
                unique case (funct3)
                    F3_ADD: begin
                        d.op  = (!is_imm && f7_alt) ? ALU_SUB : ALU_ADD;
                        legal = is_imm || f7_base || f7_alt;
                    end
                    F3_SLL: begin
                        d.op  = ALU_SLL;
                        legal = f7_base;
                        if (is_imm) d.b = shamt_i;
                    end
                    F3_SLT: begin
                        d.op  = ALU_SUB;
                        d.cmp = CMP_SLT;
                        legal = is_imm || f7_base;
                    end
                    F3_SLTU: begin
                        d.op  = ALU_SUB;
                        d.cmp = CMP_SLTU;
                        legal = is_imm || f7_base;
                    end
                    F3_XOR: begin
                        d.op  = ALU_XOR;
                        legal = is_imm || f7_base;
                    end
                    F3_SR: begin
                        d.op  = f7_alt ? ALU_SRA : ALU_SRL;
                        legal = f7_base || f7_alt;
                        if (is_imm) d.b = shamt_i;
                    end
                    F3_OR: begin
                        d.op  = ALU_OR;
                        legal = is_imm || f7_base;
                    end
                    default: begin
                        d.op  = ALU_AND;
                        legal = is_imm || f7_base;
                    end
                endcase
            end
            OPC_LUI: begin
                legal  = 1'b1;
                writes = 1'b1;
                d.op   = ALU_PASSB;
                d.b    = imm_u;
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                writes = 1'b1;
                d.op   = ALU_ADD;
                d.a    = pc_i;
                d.b    = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                legal  = 1'b1;
                writes = 1'b1;
                d.op   = ALU_ADD;
                d.a    = pc_i;
                d.b    = 32'd4;
            end
            OPC_LOAD: begin
                legal  = 1'b1;
                writes = 1'b1;
                d.op   = ALU_ADD;
                d.a    = rs1_i;
                d.b    = imm_i;
            end
            OPC_STORE: begin
                legal  = 1'b1;
                d.op   = ALU_ADD;
                d.a    = rs1_i;
                d.b    = imm_s;
            end
            default: begin
                legal  = 1'b0;
            end
        endcase

        if (legal) begin
            d.rd      = writes ? rd_f : 5'd0;
            d.wen     = writes && (rd_f != 5'd0);
            d.illegal = 1'b0;
        end else begin
            d         = '0;
            d.illegal = 1'b1;
        end
    end

    assign dec_o = d;

endmodule

// File: rtl/alu_issue.sv
// Registered issue stage: decode plus a two-entry skid buffer toward the alu.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_inst_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] in_rs1_i,
    input  logic [31:0] in_rs2_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [5:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [1:0]  cmp_o,
    output logic [4:0]  rd_o,
    output logic        wen_o,
    output logic        illegal_o
);

    issue_t dec;

    alu_issue_dec u_dec (
        .inst_i (in_inst_i),
        .pc_i   (in_pc_i),
        .rs1_i  (in_rs1_i),
        .rs2_i  (in_rs2_i),
        .dec_o  (dec)
    );

    issue_t out_q, out_d;
    issue_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    logic   accept;
    logic   consume;

    assign accept  = in_valid_i && in_ready_q;
    assign consume = out_valid_q && out_ready_i;

    // Next-state of output/skid entries; in_ready tracks "skid empty" after the edge.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d  = 1'b0;
                end
            end
            // in_ready is low whenever skid is full, so accept never collides with a skid move
            if (accept) begin
                if (!out_valid_q || consume) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign alu_op_o    = out_q.op;
    assign alu_a_o     = out_q.a;
    assign alu_b_o     = out_q.b;
    assign cmp_o       = out_q.cmp;
    assign rd_o        = out_q.rd;
    assign wen_o       = out_q.wen;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue against a queue-based reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_inst_i;
    logic [31:0] in_pc_i;
    logic [31:0] in_rs1_i;
    logic [31:0] in_rs2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [1:0]  cmp_o;
    logic [4:0]  rd_o;
    logic        wen_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_inst_i   (in_inst_i),
        .in_pc_i     (in_pc_i),
        .in_rs1_i    (in_rs1_i),
        .in_rs2_i    (in_rs2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .alu_op_o    (alu_op_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .cmp_o       (cmp_o),
        .rd_o        (rd_o),
        .wen_o       (wen_o),
        .illegal_o   (illegal_o)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  cmp;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   zero_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference decode written from the instruction-set rules.
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
        logic [5:0] op_by_f3 [8];
        exp_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i, imm_s, imm_u;
        bit ok, wr, shift;
        op_by_f3 = '{6'b010000, 6'b110000, 6'b010001, 6'b010001,
                     6'b100110, 6'b110001, 6'b101110, 6'b101000};
        opc   = inst[6:0];
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_u = {inst[31:12], 12'h000};
        e     = '{op: 6'd0, a: 32'd0, b: 32'd0, cmp: 2'd0, rd: 5'd0, wen: 1'b0, illegal: 1'b0};
        ok    = 1'b0;
        wr    = 1'b1;
        if (opc == 7'h33 || opc == 7'h13) begin
            shift = (f3 == 3'd1) || (f3 == 3'd5);
            e.a   = rs1;
            e.op  = op_by_f3[f3];
            e.cmp = (f3 == 3'd2) ? 2'b01 : (f3 == 3'd3) ? 2'b10 : 2'b00;
            if (opc == 7'h33) begin
                ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.b  = rs2;
                if (f7 == 7'h20 && f3 == 3'd0) e.op = 6'b010001;
            end else begin
                ok   = !shift || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                e.b  = shift ? {27'd0, inst[24:20]} : imm_i;
            end
            if (f7 == 7'h20 && f3 == 3'd5) e.op = 6'b110011;
        end else if (opc == 7'h37) begin
            ok = 1'b1; e.op = 6'b101010; e.b = imm_u;
        end else if (opc == 7'h17) begin
            ok = 1'b1; e.op = 6'b010000; e.a = pc; e.b = imm_u;
        end else if (opc == 7'h6F || opc == 7'h67) begin
            ok = 1'b1; e.op = 6'b010000; e.a = pc; e.b = 32'd4;
        end else if (opc == 7'h03) begin
            ok = 1'b1; e.op = 6'b010000; e.a = rs1; e.b = imm_i;
        end else if (opc == 7'h23) begin
            ok = 1'b1; wr = 1'b0; e.op = 6'b010000; e.a = rs1; e.b = imm_s;
        end
        if (!ok) begin
            e = '{op: 6'd0, a: 32'd0, b: 32'd0, cmp: 2'd0, rd: 5'd0, wen: 1'b0, illegal: 1'b1};
        end else begin
            e.rd  = wr ? inst[11:7] : 5'd0;
            e.wen = wr && (inst[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = 5'($urandom);
        r1  = 5'($urandom);
        r2  = 5'($urandom);
        f3  = 3'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 12))
            0, 1: begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'($urandom);
                endcase
                w = {f7, r2, r1, f3, rd, 7'h33};
            end
            2, 3: w = {imm, r1, f3, rd, 7'h13};
            4: begin
                f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
                f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
                w  = {f7, r2, r1, f3, rd, 7'h13};
            end
            5:  w = {20'($urandom), rd, 7'h37};
            6:  w = {20'($urandom), rd, 7'h17};
            7:  w = {20'($urandom), rd, 7'h6F};
            8:  w = {imm, r1, 3'd0, rd, 7'h67};
            9:  w = {imm, r1, f3, rd, 7'h03};
            10: w = {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
            11: w = {imm[11:5], r2, r1, f3, imm[4:0], 7'h63};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic compare_all();
        check("in_ready", 32'(in_ready_o), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("op", 32'(alu_op_o), 32'(q[0].op));
            check("a", alu_a_o, q[0].a);
            check("b", alu_b_o, q[0].b);
            check("cmp", 32'(cmp_o), 32'(q[0].cmp));
            check("rd", 32'(rd_o), 32'(q[0].rd));
            check("wen", 32'(wen_o), 32'(q[0].wen));
            check("illegal", 32'(illegal_o), 32'(q[0].illegal));
        end
        if (zero_chk) begin
            check("rst_op", 32'(alu_op_o), 32'd0);
            check("rst_a", alu_a_o, 32'd0);
            check("rst_b", alu_b_o, 32'd0);
            check("rst_cmp", 32'(cmp_o), 32'd0);
            check("rst_rd", 32'(rd_o), 32'd0);
            check("rst_wen", 32'(wen_o), 32'd0);
            check("rst_illegal", 32'(illegal_o), 32'd0);
        end
    endtask

    // Drive one cycle from the falling edge, advance the model at the rising edge, check after.
    task automatic cycle(input logic rstn, input logic fl, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy);
        bit acc, cons;
        rst_n       = rstn;
        flush_i     = fl;
        in_valid_i  = v;
        in_inst_i   = inst;
        in_pc_i     = pc;
        in_rs1_i    = r1;
        in_rs2_i    = r2;
        out_ready_i = ordy;
        @(posedge clk);
        if (!rstn || fl) begin
            q.delete();
        end else begin
            acc  = v && (q.size() < 2);
            cons = ordy && (q.size() != 0);
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(inst, pc, r1, r2));
        end
        zero_chk = !rstn;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy);
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy);
        cycle(1'b1, 1'b0, 1'b1, inst, 32'h0000_1000, r1, r2, ordy);
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_inst_i = '0; in_pc_i = '0; in_rs1_i = '0; in_rs2_i = '0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1);

        // add x3,x1,x2
        issue(32'h002081B3, 32'd5, 32'd7, 1'b1);
        check("add_valid", 32'(out_valid_o), 32'd1);
        check("add_op", 32'(alu_op_o), 32'b010000);
        check("add_a", alu_a_o, 32'd5);
        check("add_b", alu_b_o, 32'd7);
        check("add_rd", 32'(rd_o), 32'd3);
        check("add_wen", 32'(wen_o), 32'd1);
        // srai x1,x2,4
        issue(32'h40415093, 32'h8000_0000, 32'd0, 1'b1);
        check("srai_op", 32'(alu_op_o), 32'b110011);
        check("srai_sh", 32'(alu_b_o[4:0]), 32'd4);
        // sub x6,x7,x8 and xor x9,x10,x11
        issue({7'h20, 5'd8, 5'd7, 3'd0, 5'd6, 7'h33}, 32'd9, 32'd4, 1'b1);
        check("sub_op", 32'(alu_op_o), 32'b010001);
        issue({7'h00, 5'd11, 5'd10, 3'd4, 5'd9, 7'h33}, 32'd9, 32'd4, 1'b1);
        check("xor_op", 32'(alu_op_o), 32'b100110);
        // lui x5,0x12345
        issue(32'h123452B7, 32'd0, 32'd0, 1'b1);
        check("lui_op", 32'(alu_op_o), 32'b101010);
        check("lui_b", alu_b_o, 32'h12345000);
        // sltiu x4,x1,-1
        issue(32'hFFF0B213, 32'd3, 32'd0, 1'b1);
        check("sltiu_op", 32'(alu_op_o), 32'b010001);
        check("sltiu_b", alu_b_o, 32'hFFFF_FFFF);
        check("sltiu_cmp", 32'(cmp_o), 32'd2);
        // branch
        issue(32'h00000063, 32'd1, 32'd2, 1'b1);
        check("br_op", 32'(alu_op_o), 32'd0);
        check("br_ill", 32'(illegal_o), 32'd1);
        check("br_wen", 32'(wen_o), 32'd0);
        idle(1'b1);

        // Stall with three beats offered, then drain
        cycle(1'b1, 1'b0, 1'b1, 32'h00208033, 32'h100, 32'd1, 32'd1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h00208033, 32'h104, 32'd2, 32'd2, 1'b0);
        check("full_ready", 32'(in_ready_o), 32'd0);
        check("hold_a", alu_a_o, 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'h00208033, 32'h108, 32'd3, 32'd3, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h00208033, 32'h108, 32'd3, 32'd3, 1'b1);
        check("drain_ready", 32'(in_ready_o), 32'd1);
        check("drain_a", alu_a_o, 32'd2);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with both entries full and a beat offered
        issue(32'h00208033, 32'd11, 32'd0, 1'b0);
        issue(32'h00208033, 32'd12, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h00208033, 32'h0, 32'd13, 32'd0, 1'b0);
        check("flush_valid", 32'(out_valid_o), 32'd0);
        check("flush_ready", 32'(in_ready_o), 32'd1);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Mid-stream reset
        issue(32'h00208033, 32'd21, 32'd0, 1'b0);
        issue(32'h00208033, 32'd22, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h00208033, 32'h0, 32'd23, 32'd0, 1'b1);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic rr, ff, vv, oo;
            rr = ($urandom_range(0, 199) != 0);
            ff = ($urandom_range(0, 31) == 0);
            vv = ($urandom_range(0, 3) != 0);
            oo = ($urandom_range(0, 2) != 0);
            cycle(rr, ff, vv, rand_inst(), $urandom, $urandom, $urandom, oo);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered issue stage that sits in front of the execute-stage `alu`. It accepts a fetched RV32I instruction with its PC and register-file operands, and encodes it into the 6-bit `alu_op` command and the two 32-bit operands. It delivers them over a valid/ready handshake. A two-entry skid buffer sustains one instruction per cycle while keeping `in_ready_o` a pure register output.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `flush_i`  in  1  discard everything held or being accepted
- `in_valid_i`  in  1  upstream instruction valid
- `in_ready_o`  out  1  stage can accept
- `in_inst_i`  in  32  instruction word
- `in_pc_i`  in  32  instruction PC
- `in_rs1_i`, `in_rs2_i`  in  32  register operands
- `out_valid_o`  out  1  issued command valid
- `out_ready_i`  in  1  execute stage accepts
- `alu_op_o`  out  6  ALU command
- `alu_a_o`, `alu_b_o`  out  32  ALU operands
- `cmp_o`  out  2  00 none, 01 SLT signed, 10 SLTU; execute derives the bit from the SUB result
- `rd_o`  out  5  destination register
- `wen_o`  out  1  register writeback enable (0 when rd=0)
- `illegal_o`  out  1  opcode or funct not supported

## Operation
- `alu_op` encoding:
  - bit5:4: 01 = arith, 10 = bool, 11 = shift, 00 = zero result.
  - Arith: bit0 selects ADD (0) or SUB (1).
  - Bool: bits3:0 form a truth table indexed by {a,b}.
  - Shift: bits1:0 select SLL 00, SRL 01, SRA 11.
- Command constants:
  - ADD 010000, SUB 010001, AND 101000, OR 101110, XOR 100110, PASSB 101010
  - SLL 110000, SRL 110001, SRA 110011, ZERO 000000
- Decode:
  - OP / OP-IMM: a=rs1; b=rs2 or sign-extended I-immediate. Shift amount is b[4:0], with the immediate form using shamt.
  - Illegal: funct7 other than 0000000, or 0100000 for SUB/SRA/SRAI.
  - SLT/SLTI/SLTU/SLTIU: SUB plus `cmp_o`. SLTIU sign-extends the immediate and then compares unsigned.
  - LUI: PASSB, b = {imm[31:12], 12'b0}.
  - AUIPC: ADD, a = pc, b = U-immediate.
  - JAL/JALR: ADD, a = pc, b = 4 (link value).
  - LOAD: ADD, a = rs1, b = I-immediate.
  - STORE: ADD, a = rs1, b = S-immediate, wen = 0.
  - Anything else, including branches: ZERO, a = b = 0, wen = 0, illegal = 1. Illegal instructions are still issued.
- Skid buffer:
  - Output register and skid register, each with its own valid bit.
  - `in_ready_o` is registered and equals "skid empty".
  - Accept when `in_valid_i & in_ready_o`.
  - If output is empty or being consumed this cycle, the encoded word goes to the output register; otherwise it goes to skid.
  - When output is consumed and skid is full, skid moves to output.
- Flush: on the next edge both valid bits clear and `in_ready_o` goes to 1. A beat presented during flush is dropped.
- Reset has priority over flush.

## Timing
- Reset values:
  - `out_valid_o` = 0, `in_ready_o` = 1.
  - All data outputs (`alu_op_o`, `alu_a_o`, `alu_b_o`, `cmp_o`, `rd_o`, `wen_o`, `illegal_o`) = 0.
- Latency: accept at edge N gives `out_valid_o` = 1 after edge N.
- Throughput: one instruction per cycle while `out_ready_i` = 1.
- Back-pressure: output data is held stable while `out_valid_o & ~out_ready_i`.
- Full: the second accepted beat under stall fills skid, and `in_ready_o` drops after that edge. The beat offered in that same cycle is already accepted, so none is lost.
- Drain: when skid is full, one output handshake moves skid into output and raises `in_ready_o` after the same edge.
- Simultaneous accept and consume with skid empty: the new beat replaces the output register and skid stays empty.

## Structure
- Package `alu_pkg`:
  - The `alu_op` constants above.
  - RV32 opcode and funct3 constants.
  - `cmp` encodings.
  - A packed struct `issue_t` {op, a, b, cmp, rd, wen, illegal}.
- Sub-module `alu_issue_dec`: purely combinational inst/pc/rs1/rs2 → `issue_t`. The top holds only the skid buffer.

## Test plan
- `add x3,x1,x2` with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op=010000, a=5, b=7, rd=3, wen=1.
- `srai x1,x2,4` with rs1=0x80000000 → op=110011, b[4:0]=4. `sub`, `xor`, and `lui x5,0x12345` → op=101010, b=0x12345000.
- `sltiu x4,x1,-1` → op=010001, b=0xFFFFFFFF, cmp=10. Branch 0x00000063 → op=000000, illegal=1, wen=0.
- Hold out_ready=0 and stream 3 beats → first beat stays stable on the output, second fills skid, `in_ready_o`=0 after the second edge. Release → beats emerge in order on consecutive cycles with none lost or duplicated.
- Assert `flush_i` with both entries full and a new beat offered → next cycle out_valid=0, in_ready=1, and the offered beat never appears.
- Assert rst_n=0 for one cycle in mid-stream → all outputs 0 and in_ready=1 after the edge.
